// File: rtl/arb_pkg.sv
// Shared definitions for the two-pipeline shared-resource arbiter:
// FSM state encoding, default parameters and requester indices.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  localparam int REQ_1 = 0;
  localparam int REQ_2 = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer names the pipeline that wins a tie
// and moves to the other pipeline after every grant taken with advance.
module rr_arbiter_2
  import arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     ptr <= 1'b0;
    else if (advance && (|grant))   ptr <= grant[REQ_1];
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Arbitrates two pipelines onto one shared resource with at most one
// transaction in flight; handles flush-drop, backpressure and response timeout.
module shared_resource_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic              res_req_valid,
  output logic [DATA_W-1:0] res_req_data,
  output logic              res_req_tag,
  input  logic              res_req_ready,
  input  logic              res_rsp_valid,
  input  logic [DATA_W-1:0] res_rsp_data,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data_1,
  output logic [DATA_W-1:0] rsp_data_2,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              tag_q;
  logic [DATA_W-1:0] data_q;
  logic              drop;
  logic [CNT_W-1:0]  cnt;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       grant_now;
  logic       owner_flush;

  assign eligible    = req_valid & ~{flush_2, flush_1};
  assign grant_now   = (state == IDLE) && (eligible != 2'b00);
  assign owner_flush = tag_q ? flush_2 : flush_1;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (grant_now),
    .grant   (grant)
  );

  // Only the winner in an IDLE grant cycle is released; everyone else holds.
  assign stall_1 = req_valid[REQ_1] & ~flush_1 & ~((state == IDLE) & grant[REQ_1]);
  assign stall_2 = req_valid[REQ_2] & ~flush_2 & ~((state == IDLE) & grant[REQ_2]);

  assign res_req_valid = (state == ISSUE);
  assign res_req_data  = data_q;
  assign res_req_tag   = tag_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tag_q       <= 1'b0;
      data_q      <= '0;
      drop        <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
      rsp_valid   <= '0;
      rsp_data_1  <= '0;
      rsp_data_2  <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            tag_q  <= grant[REQ_2];
            data_q <= grant[REQ_2] ? req_data_2 : req_data_1;
            drop   <= 1'b0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner_flush) drop <= 1'b1;
          if (res_req_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (owner_flush) drop <= 1'b1;
          if (res_rsp_valid) begin
            state <= IDLE;
            // A flush arriving alongside the response still discards it.
            if (!(drop || owner_flush)) begin
              rsp_valid[tag_q] <= 1'b1;
              if (tag_q) rsp_data_2 <= res_rsp_data;
              else       rsp_data_1 <= res_rsp_data;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
